md_sched: RTL and testbench

- Sequences the multiply/divide datapath of the pipelined MIPS core and owns the HI/LO architectural registers.
- Sits beside the EX stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO issued from EX and models multi-cycle latency with a busy counter.
- Raises a stall request to the hazard logic whenever the instruction in ID needs HI/LO, or the md unit, while an operation is in flight.

---
 rtl/md_sched.sv | 130 +++++++++++++
 tb/tb_md_sched.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/md_sched.sv
// rtl/md_sched.sv - MIPS mult/div sequencer owning HI/LO; optional MD_SCHED_CANCEL_EN adds a cancel input
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
`ifdef MD_SCHED_CANCEL_EN
  input  logic        cancel,
`endif
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        id_md_use,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] res_hi_q, res_lo_q;
  logic        res_wr_q;

  logic [31:0] res_hi_d, res_lo_d;
  logic        res_wr_d;
  logic        cancel_w;

`ifdef MD_SCHED_CANCEL_EN
  assign cancel_w = cancel;
`else
  assign cancel_w = 1'b0;
`endif

  logic [63:0] prod_s, prod_u;
  assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};
  assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});

  // Signed divide via magnitudes so that 0x80000000 / -1 wraps to 0x80000000 rem 0.
  logic        is_sdiv;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, q_s, r_s;
  assign is_sdiv = (op == 3'd2);
  assign a_mag   = (is_sdiv && rs_val[31]) ? (32'd0 - rs_val) : rs_val;
  assign b_mag   = (is_sdiv && rt_val[31]) ? (32'd0 - rt_val) : rt_val;
  assign q_mag   = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
  assign r_mag   = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
  assign q_s     = (is_sdiv && (rs_val[31] ^ rt_val[31])) ? (32'd0 - q_mag) : q_mag;
  assign r_s     = (is_sdiv && rs_val[31]) ? (32'd0 - r_mag) : r_mag;

  always_comb begin
    res_hi_d = 32'd0;
    res_lo_d = 32'd0;
    res_wr_d = 1'b1;
    case (op)
      3'd0: {res_hi_d, res_lo_d} = prod_s;
      3'd1: {res_hi_d, res_lo_d} = prod_u;
      3'd2, 3'd3: begin
        res_hi_d = r_s;
        res_lo_d = q_s;
        res_wr_d = (rt_val != 32'd0);
      end
      default: res_wr_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      busy_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      res_wr_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !cancel_w) begin
            if (!op[2]) begin
              res_hi_q <= res_hi_d;
              res_lo_q <= res_lo_d;
              res_wr_q <= res_wr_d;
              cnt_q    <= op[1] ? DIV_N : MULT_N;
              busy_q   <= 1'b1;
              state_q  <= S_RUN;
            end else if (op == 3'd4) begin
              hi_q <= rs_val;
            end else if (op == 3'd5) begin
              lo_q <= rs_val;
            end
          end
        end
        S_RUN: begin
          // New starts are ignored here; cancel wins over completion.
          if (cancel_w) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
          end else if (cnt_q == 4'd1) begin
            if (res_wr_q) begin
              hi_q <= res_hi_q;
              lo_q <= res_lo_q;
            end
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign stall_req = id_md_use & (busy_q | (start & ~op[2]));

endmodule

// File: tb/tb_md_sched.sv
// tb/tb_md_sched.sv - directed scoreboard bench for md_sched
module tb_md_sched;

  logic        clk;
  logic        reset;
  logic        cancel;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        id_md_use;
  logic        busy, stall_req;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;
  logic [63:0] sb_q[$];

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef MD_SCHED_CANCEL_EN
    .cancel    (cancel),
`endif
    .start     (start),
    .op        (op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .id_md_use (id_md_use),
    .busy      (busy),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo)
  );

  initial begin
    clk = 1'b0;
    #1;
    forever #5 clk = ~clk;
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic mt(input logic [2:0] op_v, input logic [31:0] val);
    @(negedge clk);
    op = op_v; rs_val = val; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (op_v == 3'd4) model_hi = val; else model_lo = val;
    check32("mt_busy", {31'd0, busy}, 32'd0);
    check32("mt_hi", hi, model_hi);
    check32("mt_lo", lo, model_lo);
  endtask

  task automatic run_md(input logic [2:0] op_v, input logic [31:0] a, input logic [31:0] b,
                        input logic use_v, input int n_exp, input logic [63:0] exp_res,
                        input logic mid_mtlo, input int cancel_at);
    int cycles;
    logic [63:0] exp;
    sb_q.push_back(exp_res);
    @(negedge clk);
    op = op_v; rs_val = a; rt_val = b; id_md_use = use_v; start = 1'b1;
    #1;
    check32("issue_stall", {31'd0, stall_req}, {31'd0, use_v});
    check32("issue_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    while (busy === 1'b1 && cycles < 40) begin
      cycles++;
      check32("run_stall", {31'd0, stall_req}, {31'd0, use_v});
      check32("run_hi", hi, model_hi);
      check32("run_lo", lo, model_lo);
      if (mid_mtlo && cycles == 2) begin
        start = 1'b1; op = 3'd5; rs_val = 32'hDEADBEEF;
      end
      if (cancel_at == cycles) cancel = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cancel = 1'b0;
    end
    check_int("busy_cycles", cycles, n_exp);
    check32("done_stall", {31'd0, stall_req}, 32'd0);
    exp = sb_q.pop_front();
    model_hi = exp[63:32];
    model_lo = exp[31:0];
    check32("done_hi", hi, model_hi);
    check32("done_lo", lo, model_lo);
    @(negedge clk);
    check32("no_relaunch", {31'd0, busy}, 32'd0);
    check32("hold_lo", lo, model_lo);
    id_md_use = 1'b0;
  endtask

  initial begin
    reset = 1'b0; cancel = 1'b0; start = 1'b0; op = 3'd0;
    rs_val = 32'd0; rt_val = 32'd0; id_md_use = 1'b0;
    #2;
    check32("rst_hi", hi, 32'd0);
    check32("rst_lo", lo, 32'd0);
    check32("rst_busy", {31'd0, busy}, 32'd0);
    check32("rst_stall", {31'd0, stall_req}, 32'd0);
    #1 reset = 1'b1;

    mt(3'd4, 32'h12345678);
    mt(3'd5, 32'h55AA55AA);

    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check32("async_hi", hi, 32'd0);
    check32("async_lo", lo, 32'd0);
    reset = 1'b1;
    model_hi = 32'd0; model_lo = 32'd0;

    run_md(3'd0, 32'hFFFFFFFF, 32'd2, 1'b1, 5, {32'hFFFFFFFF, 32'hFFFFFFFE}, 1'b0, -1);
    run_md(3'd1, 32'hFFFFFFFF, 32'd2, 1'b0, 5, {32'h00000001, 32'hFFFFFFFE}, 1'b0, -1);
    run_md(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0, 10, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0, -1);
    run_md(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b1, 10, {32'h00000000, 32'h80000000}, 1'b0, -1);
    run_md(3'd3, 32'd100, 32'd7, 1'b0, 10, {32'd2, 32'd14}, 1'b0, -1);
    mt(3'd4, 32'hA);
    mt(3'd5, 32'hB);
    run_md(3'd3, 32'd7, 32'd0, 1'b0, 10, {32'hA, 32'hB}, 1'b0, -1);
    run_md(3'd0, 32'hFFFFFFFD, 32'd5, 1'b0, 5, {32'hFFFFFFFF, 32'hFFFFFFF1}, 1'b1, -1);
`ifdef MD_SCHED_CANCEL_EN
    run_md(3'd2, 32'd100, 32'd3, 1'b0, 4, {model_hi, model_lo}, 1'b0, 4);
    run_md(3'd0, 32'd3, 32'd4, 1'b0, 5, {32'd0, 32'd12}, 1'b0, -1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
